// File: rtl/tx_arbiter.sv
// Round-robin arbiter for the shared UART transmit path: latches the winner's
// status/data, issues one transmit strobe and reports done or start timeout.
module tx_arbiter #(
    parameter int unsigned REQUESTERS    = 4,
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned START_TIMEOUT = 255
) (
    input  logic                            masterClock,
    input  logic                            reset,
    input  logic [REQUESTERS-1:0]           request,
    input  logic [8*REQUESTERS-1:0]         statusIn,
    input  logic [8*WIDTH*REQUESTERS-1:0]   dataIn,
    input  logic                            transmitting,
    output logic [7:0]                      status,
    output logic [8*WIDTH-1:0]              outputData,
    output logic                            transmit,
    output logic [REQUESTERS-1:0]           grant,
    output logic [REQUESTERS-1:0]           done,
    output logic [REQUESTERS-1:0]           error,
    output logic                            busy
);

    localparam int unsigned W  = 8 * WIDTH;
    localparam int unsigned IW = $clog2(REQUESTERS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         last, last_next;
    logic [IW-1:0]         owner, owner_next;
    logic [15:0]           count, count_next;
    logic [IW-1:0]         pick;
    logic                  found;
    logic [7:0]            sel_status;
    logic [W-1:0]          sel_data;
    logic [7:0]            status_next;
    logic [W-1:0]          data_next;
    logic                  transmit_next;
    logic [REQUESTERS-1:0] grant_next, done_next, error_next;
    logic                  busy_next;

    // Search starts one past the last winner, so the previous owner is lowest priority.
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= REQUESTERS; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(last) + i) % REQUESTERS);
            if (!found && request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_status = '0;
        sel_data   = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (IW'(i) == pick) begin
                sel_status = statusIn[8*i +: 8];
                sel_data   = dataIn[W*i +: W];
            end
        end
    end

    always_comb begin
        state_next    = state;
        last_next     = last;
        owner_next    = owner;
        count_next    = count;
        status_next   = status;
        data_next     = outputData;
        transmit_next = 1'b0;
        grant_next    = grant;
        done_next     = '0;
        error_next    = '0;
        case (state)
            IDLE: begin
                if (found && !transmitting) begin
                    state_next    = ISSUE;
                    owner_next    = pick;
                    status_next   = sel_status;
                    data_next     = sel_data;
                    transmit_next = 1'b1;
                    grant_next    = '0;
                    grant_next[pick] = 1'b1;
                end
            end
            ISSUE: begin
                count_next = '0;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (transmitting) begin
                    state_next = WAIT_DONE;
                end else if ((32'(count) + 32'd1) == START_TIMEOUT) begin
                    error_next        = '0;
                    error_next[owner] = 1'b1;
                    grant_next        = '0;
                    last_next         = owner;
                    state_next        = IDLE;
                end else begin
                    count_next = count + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!transmitting) begin
                    done_next        = '0;
                    done_next[owner] = 1'b1;
                    grant_next       = '0;
                    last_next        = owner;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= IW'(REQUESTERS - 1);
            owner      <= '0;
            count      <= '0;
            status     <= '0;
            outputData <= '0;
            transmit   <= 1'b0;
            grant      <= '0;
            done       <= '0;
            error      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            last       <= last_next;
            owner      <= owner_next;
            count      <= count_next;
            status     <= status_next;
            outputData <= data_next;
            transmit   <= transmit_next;
            grant      <= grant_next;
            done       <= done_next;
            error      <= error_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed self-checking bench for tx_arbiter: single transfer, round-robin order,
// start timeout, external busy, mid-transfer input changes and async reset.
module tb_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WB = 4;
    localparam int unsigned W  = 8 * WB;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     request;
    logic [8*N-1:0]   status_in;
    logic [W*N-1:0]   data_in;
    logic             transmitting;
    logic [7:0]       status;
    logic [W-1:0]     output_data;
    logic             transmit;
    logic [N-1:0]     grant, done, error;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    tx_arbiter #(.REQUESTERS(N), .WIDTH(WB), .START_TIMEOUT(5)) dut (
        .masterClock (clk),
        .reset       (rst),
        .request     (request),
        .statusIn    (status_in),
        .dataIn      (data_in),
        .transmitting(transmitting),
        .status      (status),
        .outputData  (output_data),
        .transmit    (transmit),
        .grant       (grant),
        .done        (done),
        .error       (error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Called in the ISSUE cycle; UART raises transmitting `rise` cycles after the
    // strobe and holds it `hold` cycles. Returns in the cycle done should pulse.
    task automatic run_xfer(input string tag, input int rise, input int hold);
        int stray;
        stray = 0;
        for (int k = 1; k <= rise; k++) begin
            tick();
            if (transmit !== 1'b0 || done !== '0 || error !== '0) stray++;
            if (k == rise) transmitting = 1'b1;
        end
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (transmit !== 1'b0 || done !== '0 || error !== '0) stray++;
        end
        transmitting = 1'b0;
        tick();
        check({tag, "_quiet"}, 64'(stray), 64'd0);
    endtask

    initial begin
        logic [N-1:0] order [6];
        int stray;
        rst = 1'b1;
        request = '0;
        status_in = '0;
        data_in = '0;
        transmitting = 1'b0;
        #2;
        check("rst_status",   64'(status),      64'd0);
        check("rst_data",     64'(output_data), 64'd0);
        check("rst_transmit", 64'(transmit),    64'd0);
        check("rst_grant",    64'(grant),       64'd0);
        check("rst_done",     64'(done),        64'd0);
        check("rst_error",    64'(error),       64'd0);
        check("rst_busy",     64'(busy),        64'd0);
        tick();
        rst = 1'b0;

        // Single request from requester 2
        for (int i = 0; i < int'(N); i++) begin
            status_in[8*i +: 8] = 8'(8'h10 + i);
            data_in[W*i +: W]   = 32'h0101_0101 * (i + 1);
        end
        status_in[8*2 +: 8] = 8'hA5;
        data_in[W*2 +: W]   = 32'hDEAD_BEEF;
        request = 4'b0100;
        tick();
        check("t1_grant",    64'(grant),       64'h4);
        check("t1_transmit", 64'(transmit),    64'd1);
        check("t1_status",   64'(status),      64'hA5);
        check("t1_data",     64'(output_data), 64'hDEAD_BEEF);
        check("t1_busy",     64'(busy),        64'd1);
        run_xfer("t1", 2, 10);
        check("t1_done",      64'(done),  64'h4);
        check("t1_done_gnt",  64'(grant), 64'h0);
        check("t1_done_busy", 64'(busy),  64'd0);
        request = '0;
        tick();
        check("t1_done_once", 64'(done), 64'h0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Round-robin with all four requesting continuously
        do_reset();
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001; order[5] = 4'b0010;
        request = 4'b1111;
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr%0d_grant", i), 64'(grant), 64'(order[i]));
            check($sformatf("rr%0d_tx", i), 64'(transmit), 64'd1);
            run_xfer($sformatf("rr%0d", i), 2, 3);
            check($sformatf("rr%0d_done", i), 64'(done), 64'(order[i]));
            check($sformatf("rr%0d_busy", i), 64'(busy), 64'd0);
            if (i == 5) request = '0;
            tick();
        end

        // Start timeout: requester 0 aborts, requester 1 wins next
        do_reset();
        request = 4'b0011;
        tick();
        check("to_grant", 64'(grant), 64'h1);
        check("to_tx",    64'(transmit), 64'd1);
        stray = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (error !== '0 || done !== '0 || transmit !== 1'b0) stray++;
        end
        check("to_early", 64'(stray), 64'd0);
        tick();
        check("to_error", 64'(error), 64'h1);
        check("to_done",  64'(done),  64'h0);
        check("to_grant0", 64'(grant), 64'h0);
        check("to_busy",  64'(busy),  64'd0);
        tick();
        check("to_next_grant", 64'(grant), 64'h2);
        check("to_err_once",   64'(error), 64'h0);
        run_xfer("to", 2, 2);
        check("to_next_done", 64'(done), 64'h2);
        request = '0;
        tick();

        // External user owns the UART
        do_reset();
        transmitting = 1'b1;
        request = 4'b0001;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (transmit !== 1'b0 || busy !== 1'b0 || grant !== '0) stray++;
        end
        check("ext_hold", 64'(stray), 64'd0);
        transmitting = 1'b0;
        tick();
        check("ext_tx",    64'(transmit), 64'd1);
        check("ext_grant", 64'(grant),    64'h1);
        run_xfer("ext", 2, 2);
        check("ext_done", 64'(done), 64'h1);
        request = '0;
        tick();

        // Inputs change and request drops during WAIT_DONE
        do_reset();
        status_in[7:0] = 8'h3C;
        data_in[W-1:0] = 32'h1234_5678;
        request = 4'b0001;
        tick();
        tick();
        tick();
        transmitting = 1'b1;
        tick();
        status_in[7:0] = 8'h00;
        data_in[W-1:0] = 32'hFFFF_0000;
        request = '0;
        tick();
        check("mid_data",   64'(output_data), 64'h1234_5678);
        check("mid_status", 64'(status),      64'h3C);
        check("mid_grant",  64'(grant),       64'h1);
        transmitting = 1'b0;
        tick();
        check("mid_done", 64'(done), 64'h1);
        tick();

        // Asynchronous reset during WAIT_DONE
        request = 4'b0001;
        tick();
        tick();
        tick();
        transmitting = 1'b1;
        tick();
        tick();
        check("ar_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_grant",  64'(grant),       64'h0);
        check("ar_busy",   64'(busy),        64'd0);
        check("ar_status", 64'(status),      64'h0);
        check("ar_data",   64'(output_data), 64'h0);
        check("ar_tx",     64'(transmit),    64'd0);
        transmitting = 1'b0;
        tick();
        rst = 1'b0;
        request = 4'b1001;
        tick();
        check("ar_first_grant", 64'(grant), 64'h1);
        check("ar_first_tx",    64'(transmit), 64'd1);
        run_xfer("ar", 2, 2);
        check("ar_done", 64'(done), 64'h1);
        request = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
